// File: rtl/fp32_pkg.sv
// Shared fp32 types and constants for the FP datapath units.
// Used by the divider and the operand classifier.
package fp32_pkg;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam int          BIAS    = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, NORM, DONE} div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational fp32 operand classifier; denormals are reported as zero.
// Zero latency, no handshake.
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t     a,
  output fp_class_t cls
);

  always_comb begin
    cls = FP_NORM;
    if (a.exp == EXP_MAX) cls = (a.frac != '0) ? FP_NAN : FP_INF;
    else if (a.exp == 8'h00) cls = FP_ZERO;
  end

endmodule

// File: rtl/fp32_divider_iter.sv
// Iterative fp32 divider, radix-2 restoring, one quotient bit per clock, truncating.
// Latency: done 2 cycles after accept for specials, 28 otherwise; start ignored while busy except in DONE.
module fp32_divider_iter
  import fp32_pkg::*;
#(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR
);

  div_state_t       state;
  fp32_t            opa, opb;
  fp_class_t        ca, cb;
  logic [24:0]      rem;
  logic [23:0]      div;
  logic [QBITS-1:0] q;
  logic [4:0]       cnt;

  logic             sgn;
  logic [25:0]      trial;
  logic [9:0]       e;
  logic [22:0]      frac;
  logic             special;
  logic [31:0]      special_val;
  logic [31:0]      norm_val;

  fp32_classify u_cls_a (.a(opa), .cls(ca));
  fp32_classify u_cls_b (.a(opb), .cls(cb));

  assign sgn   = opa.sign ^ opb.sign;
  assign trial = {1'b0, rem} - {2'b00, div};

  always_comb begin
    special     = 1'b1;
    special_val = QNAN;
    if (ca == FP_NAN || cb == FP_NAN) special_val = QNAN;
    else if ((ca == FP_INF && cb == FP_INF) || (ca == FP_ZERO && cb == FP_ZERO)) special_val = QNAN;
    else if (ca == FP_INF || cb == FP_ZERO) special_val = POS_INF | {sgn, 31'b0};
    else if (ca == FP_ZERO || cb == FP_INF) special_val = {sgn, 31'b0};
    else special = 1'b0;
  end

  // Quotient lies in (0.5, 2); a clear top bit means one extra normalising shift.
  always_comb begin
    e        = {2'b00, opa.exp} - {2'b00, opb.exp} + 10'(BIAS) - {9'b0, ~q[QBITS-1]};
    frac     = q[QBITS-1] ? q[23:1] : q[22:0];
    norm_val = {sgn, e[7:0], frac};
    if ($signed(e) >= 10'sd255) norm_val = {sgn, EXP_MAX, 23'b0};
    else if ($signed(e) <= 10'sd0) norm_val = {sgn, 31'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dataR <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= dataA;
            opb   <= dataB;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (special) begin
            dataR <= special_val;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rem   <= {2'b01, opa.frac};
            div   <= {1'b1, opb.frac};
            q     <= '0;
            cnt   <= 5'(QBITS - 1);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem   <= trial[25] ? {rem[23:0], 1'b0} : {trial[23:0], 1'b0};
          q     <= {q[QBITS-2:0], ~trial[25]};
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) state <= NORM;
        end
        NORM: begin
          dataR <= norm_val;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (start) begin
            opa   <= dataA;
            opb   <= dataB;
            state <= CHECK;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider_iter.sv
// Directed bench for fp32_divider_iter: values, latency, handshake and reset behaviour.
module tb_fp32_divider_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy, done;
  logic [31:0] dataR;

  int errors = 0;
  int checks = 0;

  fp32_divider_iter #(.QBITS(25)) dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .dataR(dataR)
  );

  always #5 clk = ~clk;

  // Drives one operation and reports result, cycles-to-done (999 on timeout) and busy cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dataA = a; dataB = b;
    lat = 999; bcnt = 0; r = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; dataA = 32'hDEADBEEF; dataB = 32'h12345678;
      end
      bcnt += int'(busy);
      if (done) begin
        lat = i; r = dataR;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataR !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dataR=%h, required 0 0 00000000", busy, done, dataR);
    end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    logic [31:0] r;
    int lat, bc;
    run_op(32'h40C00000, 32'h40000000, r, lat, bc);
    checks++;
    if (r !== 32'h40400000) begin errors++; $display("FAIL div_6_2: got %h, required 40400000", r); end
    checks++;
    if (lat !== 28) begin errors++; $display("FAIL lat_6_2: got %0d, required 28", lat); end
    checks++;
    if (bc !== 28) begin errors++; $display("FAIL busy_6_2: got %0d, required 28", bc); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dataR !== 32'h40400000) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b dataR=%h, required 0 0 40400000", done, busy, dataR);
    end
    run_op(32'h3F800000, 32'h40400000, r, lat, bc);
    checks++;
    if (r !== 32'h3EAAAAAA || lat !== 28) begin
      errors++; $display("FAIL div_1_3: got %h lat %0d, required 3EAAAAAA lat 28", r, lat);
    end
    run_op(32'hBF800000, 32'h40400000, r, lat, bc);
    checks++;
    if (r !== 32'hBEAAAAAA || lat !== 28) begin
      errors++; $display("FAIL div_m1_3: got %h lat %0d, required BEAAAAAA lat 28", r, lat);
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [6] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
    logic [31:0] vb [6] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    logic [31:0] vr [6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
    logic [31:0] r;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], r, lat, bc);
      checks++;
      if (r !== vr[i] || lat !== 2 || bc !== 2) begin
        errors++;
        $display("FAIL special_%0d: %h/%h got %h lat %0d busy %0d, required %h lat 2 busy 2",
                 i, va[i], vb[i], r, lat, bc, vr[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] r;
    int lat, bc;
    run_op(32'h7F000000, 32'h3E800000, r, lat, bc);
    checks++;
    if (r !== 32'h7F800000 || lat !== 28) begin
      errors++; $display("FAIL overflow: got %h lat %0d, required 7F800000 lat 28", r, lat);
    end
    run_op(32'h00800000, 32'h40000000, r, lat, bc);
    checks++;
    if (r !== 32'h00000000 || lat !== 28) begin
      errors++; $display("FAIL underflow: got %h lat %0d, required 00000000 lat 28", r, lat);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] prev, r;
    int lat;
    logic changed;
    prev = dataR; changed = 1'b0; lat = 999; r = 'x;
    @(negedge clk);
    start = 1'b1; dataA = 32'h40C00000; dataB = 32'h40000000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; dataA = 32'h3F800000; dataB = 32'h00000000; end
      if (i == 6) start = 1'b0;
      if (done) begin lat = i; r = dataR; break; end
      if (dataR !== prev) changed = 1'b1;
    end
    checks++;
    if (changed !== 1'b0) begin errors++; $display("FAIL ignore_hold: dataR changed before done, required %h", prev); end
    checks++;
    if (r !== 32'h40400000 || lat !== 28) begin
      errors++; $display("FAIL ignore_result: got %h lat %0d, required 40400000 lat 28", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int lat1, lat2;
    logic gap;
    lat1 = 999; lat2 = 999; r1 = 'x; r2 = 'x; gap = 1'b0;
    @(negedge clk);
    start = 1'b1; dataA = 32'h3F800000; dataB = 32'h00000000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin dataA = 32'h3F800000; dataB = 32'h40400000; end
      if (done) begin lat1 = i; r1 = dataR; break; end
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b0; dataA = 32'h0; dataB = 32'h0; end
      if (busy !== 1'b1) gap = 1'b1;
      if (done) begin lat2 = i; r2 = dataR; break; end
    end
    start = 1'b0;
    checks++;
    if (r1 !== 32'h7F800000 || lat1 !== 2) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d, required 7F800000 lat 2", r1, lat1);
    end
    checks++;
    if (r2 !== 32'h3EAAAAAA || lat2 !== 28 || gap !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d gap %b, required 3EAAAAAA lat 28 gap 0", r2, lat2, gap);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    int lat, bc;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; dataA = 32'h40C00000; dataB = 32'h40000000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataR !== 32'h0 || saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b dataR=%h early_done=%b, required 0 0 00000000 0",
               busy, done, dataR, saw_done);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_abort: done seen after reset, required none"); end
    run_op(32'h3F800000, 32'h3F800000, r, lat, bc);
    checks++;
    if (r !== 32'h3F800000 || lat !== 28) begin
      errors++; $display("FAIL after_reset_op: got %h lat %0d, required 3F800000 lat 28", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
